ex_stage: RTL and testbench

// - Execute stage of the 16-bit MISC-V pipeline. Consumes the ID/EX register outputs,

---
 rtl/ex_stage.sv | 241 ++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage -- execute stage of the 16-bit MISC-V pipeline.
//
// Consumes the ID/EX register outputs, computes the ALU result and the branch
// decision, and registers the EX/MEM fields.
//
// Optional feature: define EX_STAGE_MUL_EN to build the 16-cycle shift-add
// multiplier FSM. Without it, IALUOP 111 is a single-cycle op producing 0 and
// Stall is tied low.
//
// Ports:
//   CLK, Reset          clock, synchronous active-high reset
//   IRegWrite..IRegStore  control bits from ID/EX
//   IALUSrc             1: B = IImm, 0: B = I2ndArg
//   IALUOP              000 add, 001 sub, 010 and, 011 or, 100 xor,
//                       101 sll, 110 srl, 111 mul
//   I1stArg, I2ndArg    operands A and B (register)
//   I3rdArg             store data, IImm immediate, IRd destination
//   Stall               holds ID/EX and earlier stages during a multiply
//   ORegWrite..ORegStore  registered control pass-through
//   OALUResult          registered ALU result
//   OStoreData, ORd     registered I3rdArg / IRd
//   OBranchTaken        registered IBranch & (A == B), B after the mux
// ----------------------------------------------------------------------------
module ex_stage #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             IRegWrite,
    input  logic             IALUSrc,
    input  logic [2:0]       IALUOP,
    input  logic             IBranch,
    input  logic             IMemWrite,
    input  logic             IMemRead,
    input  logic             IRegStore,
    input  logic [WIDTH-1:0] I1stArg,
    input  logic [WIDTH-1:0] I2ndArg,
    input  logic [WIDTH-1:0] I3rdArg,
    input  logic [WIDTH-1:0] IImm,
    input  logic [WIDTH-1:0] IRd,
    output logic             Stall,
    output logic             ORegWrite,
    output logic             OBranch,
    output logic             OMemWrite,
    output logic             OMemRead,
    output logic             ORegStore,
    output logic [WIDTH-1:0] OALUResult,
    output logic [WIDTH-1:0] OStoreData,
    output logic [WIDTH-1:0] ORd,
    output logic             OBranchTaken
);

    // EX/MEM output registers
    logic             regwrite_q, regwrite_d;
    logic             branch_q, branch_d;
    logic             memwrite_q, memwrite_d;
    logic             memread_q, memread_d;
    logic             regstore_q, regstore_d;
    logic             taken_q, taken_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic [WIDTH-1:0] rd_q, rd_d;

    logic [WIDTH-1:0] b_mux;
    logic [WIDTH-1:0] alu_res;
    logic             taken_c;

`ifdef EX_STAGE_MUL_EN
    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       count_q, count_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    // latched {RegWrite, Branch, MemWrite, MemRead, RegStore, BranchTaken}
    logic [5:0]       lctl_q, lctl_d;
    logic [WIDTH-1:0] lrd_q, lrd_d;
    logic [WIDTH-1:0] lsd_q, lsd_d;
    logic [WIDTH-1:0] partial;
    logic             stall_c;
`endif

    always_comb begin
        b_mux   = IALUSrc ? IImm : I2ndArg;
        taken_c = IBranch && (I1stArg == b_mux);
        case (IALUOP)
            3'b000:  alu_res = I1stArg + b_mux;
            3'b001:  alu_res = I1stArg - b_mux;
            3'b010:  alu_res = I1stArg & b_mux;
            3'b011:  alu_res = I1stArg | b_mux;
            3'b100:  alu_res = I1stArg ^ b_mux;
            3'b101:  alu_res = I1stArg << b_mux[3:0];
            3'b110:  alu_res = I1stArg >> b_mux[3:0];
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        // Single-cycle pass-through is the default behaviour.
        regwrite_d = IRegWrite;
        branch_d   = IBranch;
        memwrite_d = IMemWrite;
        memread_d  = IMemRead;
        regstore_d = IRegStore;
        taken_d    = taken_c;
        res_d      = alu_res;
        sd_d       = I3rdArg;
        rd_d       = IRd;
`ifdef EX_STAGE_MUL_EN
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        lctl_d  = lctl_q;
        lrd_d   = lrd_q;
        lsd_d   = lsd_q;
        stall_c = 1'b0;
        partial = b_q[count_q] ? (a_q << count_q) : '0;

        case (state_q)
            S_IDLE: begin
                // A mul without RegWrite is a bubble and stays single-cycle.
                if (IALUOP == 3'b111 && IRegWrite) begin
                    stall_c = 1'b1;
                    state_d = S_MUL;
                    a_d     = I1stArg;
                    b_d     = b_mux;
                    acc_d   = '0;
                    count_d = '0;
                    lctl_d  = {IRegWrite, IBranch, IMemWrite, IMemRead, IRegStore, taken_c};
                    lrd_d   = IRd;
                    lsd_d   = I3rdArg;
                    // bubble into EX/MEM: control low, data held
                    regwrite_d = 1'b0;
                    branch_d   = 1'b0;
                    memwrite_d = 1'b0;
                    memread_d  = 1'b0;
                    regstore_d = 1'b0;
                    taken_d    = 1'b0;
                    res_d      = res_q;
                    sd_d       = sd_q;
                    rd_d       = rd_q;
                end
            end
            S_MUL: begin
                acc_d   = acc_q + partial;
                count_d = count_q + 4'd1;
                if (count_q != 4'd15) begin
                    stall_c    = 1'b1;
                    regwrite_d = 1'b0;
                    branch_d   = 1'b0;
                    memwrite_d = 1'b0;
                    memread_d  = 1'b0;
                    regstore_d = 1'b0;
                    taken_d    = 1'b0;
                    res_d      = res_q;
                    sd_d       = sd_q;
                    rd_d       = rd_q;
                end else begin
                    // last partial product is folded in on the writing edge
                    state_d    = S_IDLE;
                    {regwrite_d, branch_d, memwrite_d, memread_d, regstore_d, taken_d} = lctl_q;
                    res_d      = acc_q + partial;
                    sd_d       = lsd_q;
                    rd_d       = lrd_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
`endif
    end

`ifdef EX_STAGE_MUL_EN
    assign Stall = stall_c & ~Reset;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            lctl_q  <= '0;
            lrd_q   <= '0;
            lsd_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            lctl_q  <= lctl_d;
            lrd_q   <= lrd_d;
            lsd_q   <= lsd_d;
        end
    end
`else
    assign Stall = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            regwrite_q <= 1'b0;
            branch_q   <= 1'b0;
            memwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            regstore_q <= 1'b0;
            taken_q    <= 1'b0;
            res_q      <= '0;
            sd_q       <= '0;
            rd_q       <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            branch_q   <= branch_d;
            memwrite_q <= memwrite_d;
            memread_q  <= memread_d;
            regstore_q <= regstore_d;
            taken_q    <= taken_d;
            res_q      <= res_d;
            sd_q       <= sd_d;
            rd_q       <= rd_d;
        end
    end

    assign ORegWrite    = regwrite_q;
    assign OBranch      = branch_q;
    assign OMemWrite    = memwrite_q;
    assign OMemRead     = memread_q;
    assign ORegStore    = regstore_q;
    assign OBranchTaken = taken_q;
    assign OALUResult   = res_q;
    assign OStoreData   = sd_q;
    assign ORd          = rd_q;

endmodule

// File: tb/tb_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_stage -- self-checking bench for ex_stage. Builds for either setting
// of EX_STAGE_MUL_EN, matching the design build.
// ----------------------------------------------------------------------------
module tb_ex_stage;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        IRegWrite, IALUSrc, IBranch, IMemWrite, IMemRead, IRegStore;
    logic [2:0]  IALUOP;
    logic [15:0] I1stArg, I2ndArg, I3rdArg, IImm, IRd;
    logic        Stall;
    logic        ORegWrite, OBranch, OMemWrite, OMemRead, ORegStore, OBranchTaken;
    logic [15:0] OALUResult, OStoreData, ORd;

    int checks = 0;
    int errors = 0;

    // last values written into EX/MEM; bubbles must leave data here
    logic [15:0] prev_res = '0;
    logic [15:0] prev_sd  = '0;
    logic [15:0] prev_rd  = '0;

    ex_stage #(.WIDTH(16)) dut (
        .CLK(CLK), .Reset(Reset),
        .IRegWrite(IRegWrite), .IALUSrc(IALUSrc), .IALUOP(IALUOP),
        .IBranch(IBranch), .IMemWrite(IMemWrite), .IMemRead(IMemRead),
        .IRegStore(IRegStore),
        .I1stArg(I1stArg), .I2ndArg(I2ndArg), .I3rdArg(I3rdArg),
        .IImm(IImm), .IRd(IRd),
        .Stall(Stall),
        .ORegWrite(ORegWrite), .OBranch(OBranch), .OMemWrite(OMemWrite),
        .OMemRead(OMemRead), .ORegStore(ORegStore),
        .OALUResult(OALUResult), .OStoreData(OStoreData), .ORd(ORd),
        .OBranchTaken(OBranchTaken)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference ALU: plain arithmetic on the operand values.
    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        int unsigned sh;
        int unsigned prod;
        sh = b % 16;
        case (op)
            3'd0: return 16'((a + b) % 65536);
            3'd1: return 16'((65536 + a - b) % 65536);
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return 16'((a * (1 << sh)) % 65536);
            3'd6: return 16'(a / (1 << sh));
            default: begin
`ifdef EX_STAGE_MUL_EN
                prod = a * b;
                return 16'(prod % 65536);
`else
                prod = 0;
                return 16'(prod);
`endif
            end
        endcase
    endfunction

    task automatic drive(input logic [2:0] op, input logic rw, input logic src,
                         input logic br, input logic mw, input logic mr, input logic rs,
                         input logic [15:0] a, input logic [15:0] b2, input logic [15:0] sd,
                         input logic [15:0] imm, input logic [15:0] rd);
        IALUOP = op; IRegWrite = rw; IALUSrc = src; IBranch = br;
        IMemWrite = mw; IMemRead = mr; IRegStore = rs;
        I1stArg = a; I2ndArg = b2; I3rdArg = sd; IImm = imm; IRd = rd;
    endtask

    // Present one instruction, follow any stall, and check the EX/MEM result.
    task automatic do_op(input string tag, input logic [2:0] op, input logic rw,
                         input logic src, input logic br, input logic mw, input logic mr,
                         input logic rs, input logic [15:0] a, input logic [15:0] b2,
                         input logic [15:0] sd, input logic [15:0] imm, input logic [15:0] rd);
        logic [15:0] bm;
        logic [15:0] exp_res;
        int          stalls;
        int          exp_stalls;
        bm      = src ? imm : b2;
        exp_res = ref_alu(op, a, bm);
`ifdef EX_STAGE_MUL_EN
        exp_stalls = (op == 3'd7 && rw) ? 16 : 0;
`else
        exp_stalls = 0;
`endif
        drive(op, rw, src, br, mw, mr, rs, a, b2, sd, imm, rd);
        #1;
        stalls = 0;
        while (Stall === 1'b1 && stalls < 40) begin
            stalls++;
            @(posedge CLK); #1;
            check({tag, ".bubble_ctl"},
                  {26'd0, ORegWrite, OBranch, OMemWrite, OMemRead, ORegStore, OBranchTaken}, 0);
            check({tag, ".bubble_res"}, {16'd0, OALUResult}, {16'd0, prev_res});
        end
        check({tag, ".stall_cycles"}, stalls, exp_stalls);
        @(posedge CLK); #1;
        check({tag, ".res"}, {16'd0, OALUResult}, {16'd0, exp_res});
        check({tag, ".ctl"}, {27'd0, ORegWrite, OBranch, OMemWrite, OMemRead, ORegStore},
              {27'd0, rw, br, mw, mr, rs});
        check({tag, ".taken"}, {31'd0, OBranchTaken}, {31'd0, br && (a == bm)});
        check({tag, ".sd_rd"}, {OStoreData, ORd}, {sd, rd});
        prev_res = exp_res;
        prev_sd  = sd;
        prev_rd  = rd;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ctl"},
              {26'd0, ORegWrite, OBranch, OMemWrite, OMemRead, ORegStore, OBranchTaken}, 0);
        check({tag, ".res"}, {16'd0, OALUResult}, 0);
        check({tag, ".sd_rd"}, {OStoreData, ORd}, 0);
    endtask

    initial begin
        Reset = 1'b1;
        drive(3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1111, 16'h1111, 16'h2222,
              16'h3333, 16'h4444);
        repeat (2) @(posedge CLK);
        #1;
        check_all_zero("reset");
        check("reset.stall", {31'd0, Stall}, 0);
        Reset = 1'b0;

        do_op("add",  3'd0, 1, 0, 0, 0, 0, 0, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 16'h0003);
        do_op("sub",  3'd1, 1, 1, 0, 0, 0, 1, 16'h0000, 16'hAAAA, 16'h5555, 16'h0001, 16'h0004);
        do_op("srl",  3'd6, 1, 0, 0, 0, 0, 0, 16'h8000, 16'h0013, 16'h0000, 16'h0000, 16'h0005);
        do_op("beq1", 3'd0, 0, 0, 1, 0, 0, 0, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 16'h0000);
        do_op("beq0", 3'd0, 0, 0, 1, 0, 0, 0, 16'h1234, 16'h1235, 16'h0000, 16'h0000, 16'h0000);
        do_op("mul_a", 3'd7, 1, 0, 0, 0, 0, 0, 16'h0123, 16'h0045, 16'h0BAD, 16'h0000, 16'h0007);
        do_op("mul_b", 3'd7, 1, 0, 0, 0, 0, 0, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 16'h0001);
        // back-to-back with bit 15 of B set
        do_op("mul_c", 3'd7, 1, 1, 0, 1, 0, 0, 16'hFFFF, 16'h0000, 16'h0042, 16'h8001, 16'h0002);

        // Reset in the middle of a multiply
        drive(3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00FF, 16'h00FF, 16'h0000,
              16'h0000, 16'h0009);
        #1;
        repeat (6) @(posedge CLK);
        #1;
        Reset = 1'b1;
        #1;
        check("rst_mul.stall", {31'd0, Stall}, 0);
        @(posedge CLK); #1;
        check_all_zero("rst_mul");
        Reset = 1'b0;
        prev_res = '0; prev_sd = '0; prev_rd = '0;
        do_op("mul_after_rst", 3'd7, 1, 0, 0, 0, 0, 0, 16'h00FF, 16'h00FF, 16'h0000,
              16'h0000, 16'h0009);

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic        rw, src;
            logic [15:0] a, b2;
            op  = 3'($urandom_range(0, 7));
            rw  = 1'($urandom);
            src = 1'($urandom);
            a   = 16'($urandom);
            b2  = 16'($urandom);
`ifdef EX_STAGE_MUL_EN
            if (op == 3'd7) rw = 1'b1;
`endif
            if ($urandom_range(0, 3) == 0) begin
                src = 1'b0;
                b2  = a;
            end
            do_op("rand", op, rw, src, 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), a, b2, 16'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
